// File: rtl/verdict_pkg.sv
// Purpose: shared widths, the snapshot record and the priority helper for the verdict serializer.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package verdict_pkg;

    localparam int NUM_OUTPUTS = 10;
    localparam int DATA_W      = 64;
    localparam int TS_W        = 32;
    localparam int IDX_W       = $clog2(NUM_OUTPUTS);

    // One monitor sample: the cycle it was taken, which outputs were active, and all values.
    typedef struct packed {
        logic [TS_W-1:0]                    ts;
        logic [NUM_OUTPUTS-1:0]             aktv;
        logic [NUM_OUTPUTS-1:0][DATA_W-1:0] values;
    } snapshot_t;

    // Index of the lowest set bit; returns 0 for an empty mask (callers never ask then).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_OUTPUTS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/verdict_serializer_fifo.sv
// Purpose: snapshot queue, DEPTH entries, combinational head read.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push refused when full unless a pop happens on the same edge.
module snapshot_fifo
    import verdict_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_vld,
    input  snapshot_t push_dat,
    output logic      push_acc,
    input  logic      pop_vld,
    output snapshot_t head_dat,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    snapshot_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    // Accept a push when there is room now, or when the head leaves on this same edge.
    always_comb begin
        empty    = (count == '0);
        do_pop   = pop_vld && !empty;
        push_acc = push_vld && ((count != FULL_CNT) || do_pop);
        head_dat = mem[rd_ptr];
    end

    // Storage carries no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_acc, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/verdict_serializer.sv
// Purpose: capture timestamped monitor snapshots and emit one record per active output.
// Latency: snapshot captured at edge N presents its first record in cycle N+1 if the queue was empty.
// Backpressure: rec_ready low holds the record; full queue drops snapshots and counts them.
module verdict_serializer
    import verdict_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_values,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [IDX_W-1:0]              rec_idx,
    output logic [DATA_W-1:0]             rec_value,
    output logic [TS_W-1:0]               rec_ts,
    output logic                          rec_last,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_count
);

    logic [TS_W-1:0]        ts_q;
    logic [NUM_OUTPUTS-1:0] done_mask_q;
    logic [NUM_OUTPUTS-1:0] pend_mask;
    logic [NUM_OUTPUTS-1:0] idx_onehot;
    logic [IDX_W-1:0]       head_idx;
    logic                   head_last;
    logic                   capture;
    logic                   push_acc;
    logic                   fifo_empty;
    logic                   accept;
    logic                   pop;
    snapshot_t              cap_snap;
    snapshot_t              head_snap;

    // Build the snapshot from the current monitor outputs; ts is the pre-increment count.
    always_comb begin
        capture         = en && (|out_aktv);
        cap_snap.ts     = ts_q;
        cap_snap.aktv   = out_aktv;
        cap_snap.values = out_values;
    end

    snapshot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (capture),
        .push_dat (cap_snap),
        .push_acc (push_acc),
        .pop_vld  (pop),
        .head_dat (head_snap),
        .empty    (fifo_empty)
    );

    // Pick the lowest still-pending output of the head snapshot and decide if it is the last one.
    always_comb begin
        pend_mask  = head_snap.aktv & ~done_mask_q;
        head_idx   = lowest_set(pend_mask);
        idx_onehot = NUM_OUTPUTS'(1) << head_idx;
        head_last  = ((pend_mask & ~idx_onehot) == '0);
        accept     = !fifo_empty && rec_ready;
        pop        = accept && head_last;
    end

    // Drive the record; all payload fields read as zero while nothing is offered.
    always_comb begin
        rec_valid = !fifo_empty;
        rec_idx   = '0;
        rec_value = '0;
        rec_ts    = '0;
        rec_last  = 1'b0;
        if (!fifo_empty) begin
            rec_idx   = head_idx;
            rec_value = head_snap.values[head_idx];
            rec_ts    = head_snap.ts;
            rec_last  = head_last;
        end
    end

    // Free-running cycle stamp, advanced only while the monitor is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else if (en) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Track which outputs of the head snapshot have already been handed to the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_mask_q <= '0;
        end else if (pop) begin
            done_mask_q <= '0;
        end else if (accept) begin
            done_mask_q <= done_mask_q | idx_onehot;
        end
    end

    // Record snapshots refused by a full queue; the counter saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (capture && !push_acc) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

endmodule
